// File: rtl/nn_search_engine.sv
// -----------------------------------------------------------------------------
// nn_search_engine
//
// Streams up to MAXC candidate vectors past a latched query vector and reports
// the index and distance of the nearest one. The metric is Manhattan (sum of
// per-dimension |diff|) or Chebyshev (max |diff|). Datapath is a 3-stage
// pipeline: |diff| per dimension -> reduction -> running minimum.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-low reset
//   start         one-cycle pulse, honoured in IDLE or DONE only
//   query         DIM*CW query vector, component 0 in the LSBs (latched on start)
//   num_cand      candidates to scan, 0..MAXC, clamped to MAXC (latched on start)
//   mode          0 = Manhattan, 1 = Chebyshev (latched on start)
//   cand_valid    cand_data is valid
//   cand_data     DIM*CW candidate vector, same packing as query
//   cand_ready    engine accepts a candidate (handshake = valid & ready)
//   busy          high in RUN and FLUSH
//   result_valid  result fields valid; held until next start or reset
//   result_idx    zero-based handshake index of the nearest candidate
//   result_dist   distance of the nearest candidate
// -----------------------------------------------------------------------------
module nn_search_engine #(
    parameter int DIM  = 3,
    parameter int CW   = 8,
    parameter int MAXC = 64,
    localparam int IW  = $clog2(MAXC),
    localparam int DW  = CW + $clog2(DIM) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DIM*CW-1:0]   query,
    input  logic [IW:0]         num_cand,
    input  logic                mode,
    input  logic                cand_valid,
    input  logic [DIM*CW-1:0]   cand_data,
    output logic                cand_ready,
    output logic                busy,
    output logic                result_valid,
    output logic [IW-1:0]       result_idx,
    output logic [DW-1:0]       result_dist
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [IW:0] MAXC_N = (IW+1)'(MAXC);

    state_t              state, state_nx;

    logic [DIM*CW-1:0]   query_q;
    logic [IW:0]         n_q;
    logic                mode_q;
    logic [IW:0]         acc_cnt;
    logic [IW:0]         num_clamped;

    logic                start_ok;
    logic                hs;
    logic                last_hs;
    logic                drained;
    logic                flush_armed;

    logic [CW-1:0]       abs_diff [DIM];
    logic [CW-1:0]       s1_diff  [DIM];
    logic [IW-1:0]       s1_idx;
    logic                s1_valid;

    logic [DW-1:0]       red_sum, red_max, red_dist;
    logic [DW-1:0]       s2_dist;
    logic [IW-1:0]       s2_idx;
    logic                s2_valid;

    logic [DW-1:0]       min_dist;
    logic [IW-1:0]       min_idx;

    assign num_clamped = (num_cand > MAXC_N) ? MAXC_N : num_cand;
    assign start_ok    = start && ((state == IDLE) || (state == DONE));
    assign cand_ready  = (state == RUN) && (acc_cnt < n_q);
    assign busy        = (state == RUN) || (state == FLUSH);
    assign hs          = cand_valid && cand_ready;
    assign last_hs     = hs && ((acc_cnt + 1'b1) == n_q);
    // flush_armed blocks completion on the first FLUSH cycle, so an empty
    // search finishes two edges after start and a real one three edges after
    // its last handshake (stage 1 and stage 2 valids cover the rest).
    assign drained     = (state == FLUSH) && flush_armed && !s1_valid && !s2_valid;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples
        // the pre-edge value of its inputs, independent of statement order.
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        // NOTE: default first, so no path leaves state_nx unassigned and
        // no latch is inferred.
        state_nx = state;
        case (state)
            IDLE, DONE: if (start_ok) state_nx = (num_clamped == '0) ? FLUSH : RUN;
            RUN:        if (last_hs)  state_nx = FLUSH;
            FLUSH:      if (drained)  state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------- combinational
    always_comb begin
        for (int d = 0; d < DIM; d++) begin
            logic [CW-1:0] c, q;
            c = cand_data[d*CW +: CW];
            q = query_q[d*CW +: CW];
            abs_diff[d] = (c >= q) ? (c - q) : (q - c);
        end
    end

    // DW leaves room for DIM full-scale components, so the sum cannot wrap.
    always_comb begin
        red_sum = '0;
        red_max = '0;
        for (int d = 0; d < DIM; d++) begin
            red_sum = red_sum + DW'(s1_diff[d]);
            if (DW'(s1_diff[d]) > red_max) red_max = DW'(s1_diff[d]);
        end
        red_dist = mode_q ? red_max : red_sum;
    end

    // ------------------------------------------------- control with reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_cnt      <= '0;
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            flush_armed  <= 1'b0;
            result_valid <= 1'b0;
            result_idx   <= '0;
            result_dist  <= '0;
        end else begin
            s1_valid    <= hs;
            s2_valid    <= s1_valid;
            flush_armed <= (state == FLUSH);

            if (start_ok)  acc_cnt <= '0;
            else if (hs)   acc_cnt <= acc_cnt + 1'b1;

            if (start_ok) begin
                result_valid <= 1'b0;
            end else if (drained) begin
                result_valid <= 1'b1;
                result_idx   <= min_idx;
                result_dist  <= min_dist;
            end
        end
    end

    // ------------------------------------------------ datapath, no reset
    // NOTE: these registers are qualified by the valid bits or reloaded on
    // start, so they carry no reset; only the control state above does.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            query_q  <= query;
            n_q      <= num_clamped;
            mode_q   <= mode;
            min_dist <= '1;
            min_idx  <= '0;
        end else if (s2_valid && (s2_dist < min_dist)) begin
            // Strict compare: ties keep the earlier (lower) index.
            min_dist <= s2_dist;
            min_idx  <= s2_idx;
        end

        if (hs) begin
            s1_diff <= abs_diff;
            s1_idx  <= acc_cnt[IW-1:0];
        end

        if (s1_valid) begin
            s2_dist <= red_dist;
            s2_idx  <= s1_idx;
        end
    end

endmodule

// File: tb/tb_nn_search_engine.sv
// -----------------------------------------------------------------------------
// tb_nn_search_engine
//
// Directed bench for nn_search_engine (DIM=3, CW=8, MAXC=64). Inputs are
// driven and outputs sampled on the falling edge; expected values are
// hand-computed constants for each scenario.
// -----------------------------------------------------------------------------
module tb_nn_search_engine;

    localparam int DIM  = 3;
    localparam int CW   = 8;
    localparam int MAXC = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [23:0] query = '0;
    logic [6:0]  num_cand = '0;
    logic        mode = 1'b0;
    logic        cand_valid = 1'b0;
    logic [23:0] cand_data = '0;
    logic        cand_ready;
    logic        busy;
    logic        result_valid;
    logic [5:0]  result_idx;
    logic [10:0] result_dist;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] cand_mem [64];

    // Outputs of the search stimulus task.
    int          s_hs;
    int          s_lat;
    logic [5:0]  s_idx;
    logic [10:0] s_dist;
    logic        s_to;
    logic        s_rv0;
    logic        s_busy0;
    logic        s_ready_last;

    nn_search_engine #(.DIM(DIM), .CW(CW), .MAXC(MAXC)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .query        (query),
        .num_cand     (num_cand),
        .mode         (mode),
        .cand_valid   (cand_valid),
        .cand_data    (cand_data),
        .cand_ready   (cand_ready),
        .busy         (busy),
        .result_valid (result_valid),
        .result_idx   (result_idx),
        .result_dist  (result_dist)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] vec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {c, b, a};
    endfunction

    // Pulses start, then feeds cand_mem in handshake order using a repeating
    // cand_valid pattern until result_valid. s_lat counts edges from the final
    // handshake (or from start when nothing is accepted) to result_valid.
    task automatic search(input logic [23:0] q, input logic [6:0] n, input logic md,
                          input int plen, input logic [15:0] pat, input int glitch);
        int   cyc;
        int   last;
        logic will;
        query = q; num_cand = n; mode = md; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s_rv0 = result_valid;
        s_busy0 = busy;
        cyc = 1; last = 1; s_hs = 0; s_ready_last = 1'b0;
        while (cyc < 500 && !result_valid) begin
            cand_valid = pat[(cyc-1) % plen];
            cand_data  = cand_mem[s_hs % 64];
            if (cyc == glitch) begin
                start = 1'b1;
                num_cand = '0;
            end
            will = cand_valid && cand_ready;
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (will) begin
                s_hs++;
                last = cyc;
                s_ready_last = cand_ready;
            end
        end
        cand_valid = 1'b0;
        s_to   = !result_valid;
        s_lat  = cyc - last;
        s_idx  = result_idx;
        s_dist = result_dist;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (cand_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cand_ready: got %b expected 0", cand_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_result_valid: got %b expected 0", result_valid); end
        n_checks++; if (result_idx !== 6'd0) begin n_fail++; $display("FAIL reset_result_idx: got %0d expected 0", result_idx); end
        n_checks++; if (result_dist !== 11'd0) begin n_fail++; $display("FAIL reset_result_dist: got %0d expected 0", result_dist); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_scan;
        for (int i = 0; i < 64; i++) cand_mem[i] = vec(8'(100 + i), 8'd150, 8'd250);
        cand_mem[17] = vec(8'd12, 8'd19, 8'd30);
        search(vec(8'd10, 8'd20, 8'd30), 7'd64, 1'b0, 1, 16'h1, 0);
        n_checks++; if (s_to) begin n_fail++; $display("FAIL full_timeout: got result_valid 0 expected 1"); end
        n_checks++; if (s_busy0 !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b expected 1", s_busy0); end
        n_checks++; if (s_hs != 64) begin n_fail++; $display("FAIL full_handshakes: got %0d expected 64", s_hs); end
        n_checks++; if (s_idx !== 6'd17) begin n_fail++; $display("FAIL full_idx: got %0d expected 17", s_idx); end
        n_checks++; if (s_dist !== 11'd3) begin n_fail++; $display("FAIL full_dist: got %0d expected 3", s_dist); end
        n_checks++; if (s_lat != 3) begin n_fail++; $display("FAIL full_latency: got %0d expected 3", s_lat); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_done: got %b expected 0", busy); end
    endtask

    task automatic test_clamp;
        search(vec(8'd10, 8'd20, 8'd30), 7'd100, 1'b0, 1, 16'h1, 0);
        n_checks++; if (s_rv0 !== 1'b0) begin n_fail++; $display("FAIL clamp_rv_cleared: got %b expected 0", s_rv0); end
        n_checks++; if (s_hs != 64) begin n_fail++; $display("FAIL clamp_handshakes: got %0d expected 64", s_hs); end
        n_checks++; if (s_idx !== 6'd17) begin n_fail++; $display("FAIL clamp_idx: got %0d expected 17", s_idx); end
        n_checks++; if (s_dist !== 11'd3) begin n_fail++; $display("FAIL clamp_dist: got %0d expected 3", s_dist); end
    endtask

    task automatic test_tie;
        for (int i = 0; i < 64; i++) cand_mem[i] = vec(8'd50, 8'd50, 8'd50);
        cand_mem[5] = vec(8'd10, 8'd20, 8'd30);
        cand_mem[9] = vec(8'd10, 8'd20, 8'd30);
        search(vec(8'd10, 8'd20, 8'd30), 7'd12, 1'b0, 1, 16'h1, 0);
        n_checks++; if (s_to) begin n_fail++; $display("FAIL tie_timeout: got result_valid 0 expected 1"); end
        n_checks++; if (s_idx !== 6'd5) begin n_fail++; $display("FAIL tie_idx: got %0d expected 5", s_idx); end
        n_checks++; if (s_dist !== 11'd0) begin n_fail++; $display("FAIL tie_dist: got %0d expected 0", s_dist); end
    endtask

    task automatic test_metric;
        cand_mem[0] = vec(8'd3, 8'd3, 8'd3);
        cand_mem[1] = vec(8'd5, 8'd0, 8'd0);
        search(24'd0, 7'd2, 1'b0, 1, 16'h1, 0);
        n_checks++; if (s_idx !== 6'd1) begin n_fail++; $display("FAIL manhattan_idx: got %0d expected 1", s_idx); end
        n_checks++; if (s_dist !== 11'd5) begin n_fail++; $display("FAIL manhattan_dist: got %0d expected 5", s_dist); end
        search(24'd0, 7'd2, 1'b1, 1, 16'h1, 0);
        n_checks++; if (s_idx !== 6'd0) begin n_fail++; $display("FAIL chebyshev_idx: got %0d expected 0", s_idx); end
        n_checks++; if (s_dist !== 11'd3) begin n_fail++; $display("FAIL chebyshev_dist: got %0d expected 3", s_dist); end
    endtask

    task automatic test_overflow;
        cand_mem[0] = vec(8'd0, 8'd0, 8'd0);
        search(vec(8'd255, 8'd255, 8'd255), 7'd1, 1'b0, 1, 16'h1, 0);
        n_checks++; if (s_dist !== 11'd765) begin n_fail++; $display("FAIL overflow_dist: got %0d expected 765", s_dist); end
        n_checks++; if (s_idx !== 6'd0) begin n_fail++; $display("FAIL overflow_idx: got %0d expected 0", s_idx); end
        n_checks++; if (s_lat != 3) begin n_fail++; $display("FAIL overflow_latency: got %0d expected 3", s_lat); end
    endtask

    task automatic test_gaps;
        for (int i = 0; i < 64; i++) cand_mem[i] = vec(8'd0, 8'd0, 8'd0);
        cand_mem[0] = vec(8'd9, 8'd9, 8'd9);
        cand_mem[1] = vec(8'd8, 8'd8, 8'd8);
        cand_mem[2] = vec(8'd7, 8'd7, 8'd7);
        cand_mem[3] = vec(8'd1, 8'd0, 8'd0);
        // pattern 1,0,0,1,1,0,1 with bit 0 first
        search(24'd0, 7'd4, 1'b0, 7, 16'b1011001, 0);
        n_checks++; if (s_hs != 4) begin n_fail++; $display("FAIL gaps_handshakes: got %0d expected 4", s_hs); end
        n_checks++; if (s_ready_last !== 1'b0) begin n_fail++; $display("FAIL gaps_ready_after: got %b expected 0", s_ready_last); end
        n_checks++; if (s_idx !== 6'd3) begin n_fail++; $display("FAIL gaps_idx: got %0d expected 3", s_idx); end
        n_checks++; if (s_dist !== 11'd1) begin n_fail++; $display("FAIL gaps_dist: got %0d expected 1", s_dist); end
        n_checks++; if (s_lat != 3) begin n_fail++; $display("FAIL gaps_latency: got %0d expected 3", s_lat); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 64; i++) cand_mem[i] = vec(8'd0, 8'd0, 8'd0);
        cand_mem[0] = vec(8'd5, 8'd0, 8'd0);
        cand_mem[1] = vec(8'd2, 8'd0, 8'd0);
        cand_mem[2] = vec(8'd4, 8'd0, 8'd0);
        // restart straight from DONE, with a start pulse injected mid-run
        search(24'd0, 7'd3, 1'b1, 1, 16'h1, 2);
        n_checks++; if (s_rv0 !== 1'b0) begin n_fail++; $display("FAIL b2b_rv_cleared: got %b expected 0", s_rv0); end
        n_checks++; if (s_hs != 3) begin n_fail++; $display("FAIL b2b_handshakes: got %0d expected 3", s_hs); end
        n_checks++; if (s_idx !== 6'd1) begin n_fail++; $display("FAIL b2b_idx: got %0d expected 1", s_idx); end
        n_checks++; if (s_dist !== 11'd2) begin n_fail++; $display("FAIL b2b_dist: got %0d expected 2", s_dist); end
    endtask

    task automatic test_reset_mid;
        int   hs;
        int   cyc;
        logic will;
        query = 24'd0; num_cand = 7'd20; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rv_cleared: got %b expected 0", result_valid); end
        n_checks++; if (result_idx !== 6'd1) begin n_fail++; $display("FAIL mid_idx_held: got %0d expected 1", result_idx); end
        n_checks++; if (result_dist !== 11'd2) begin n_fail++; $display("FAIL mid_dist_held: got %0d expected 2", result_dist); end
        hs = 0; cyc = 0;
        while (hs < 10 && cyc < 100) begin
            cand_valid = 1'b1;
            cand_data  = vec(8'd1, 8'd1, 8'd1);
            will = cand_ready;
            @(negedge clk);
            cyc++;
            if (will) hs++;
        end
        n_checks++; if (hs != 10) begin n_fail++; $display("FAIL mid_handshakes: got %0d expected 10", hs); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", busy); end
        rst = 1'b0;
        cand_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (cand_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 0", cand_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rv: got %b expected 0", result_valid); end
        n_checks++; if (result_idx !== 6'd0) begin n_fail++; $display("FAIL mid_rst_idx: got %0d expected 0", result_idx); end
        n_checks++; if (result_dist !== 11'd0) begin n_fail++; $display("FAIL mid_rst_dist: got %0d expected 0", result_dist); end
        rst = 1'b1;
        @(negedge clk);
        search(24'd0, 7'd0, 1'b0, 1, 16'h1, 0);
        n_checks++; if (s_to) begin n_fail++; $display("FAIL empty_timeout: got result_valid 0 expected 1"); end
        n_checks++; if (s_hs != 0) begin n_fail++; $display("FAIL empty_handshakes: got %0d expected 0", s_hs); end
        n_checks++; if (s_lat != 2) begin n_fail++; $display("FAIL empty_latency: got %0d expected 2", s_lat); end
        n_checks++; if (s_dist !== 11'h7FF) begin n_fail++; $display("FAIL empty_dist: got %0d expected 2047", s_dist); end
        n_checks++; if (s_idx !== 6'd0) begin n_fail++; $display("FAIL empty_idx: got %0d expected 0", s_idx); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_full_scan;
        test_clamp;
        test_tie;
        test_metric;
        test_overflow;
        test_gaps;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached (got timeout expected completion)");
        $fatal(1, "watchdog expired");
    end

endmodule
